// File: rtl/tsense_pkg.sv
// Shared types and width helper for the temperature-sense sequencer.
package tsense_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PRECHARGE = 4'd1,
        ST_BLANK     = 4'd2,
        ST_BIGDIODE  = 4'd3,
        ST_DIODE     = 4'd4,
        ST_HCHARGE   = 4'd5,
        ST_LCHARGE   = 4'd6,
        ST_OUTPUT    = 4'd7,
        ST_HOLD      = 4'd8
    } state_e;

    // Bits needed to index n distinct values (minimum 1)
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tsense_cmp_sync.sv
// Two-flop synchroniser bringing the analog comparator into the clk domain.
module tsense_cmp_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic cmp,
    output logic scmp
);

    logic meta_q;
    logic scmp_q;

    // Double-register the asynchronous comparator level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            scmp_q <= 1'b0;
        end else begin
            meta_q <= cmp;
            scmp_q <= meta_q;
        end
    end

    assign scmp = scmp_q;

endmodule

// File: rtl/tsense_seq.sv
// Diode temperature-sense conversion sequencer: switch phasing, tracking
// counter, H/L accumulation and result handshake.
module tsense_seq
    import tsense_pkg::*;
#(
    parameter  int unsigned N_CH       = 4,
    parameter  int unsigned PRECHG_CYC = 26,
    parameter  int unsigned DIODE_CYC  = 9,
    parameter  int unsigned CHARGE_CYC = 6,
    parameter  int unsigned N_AVG      = 4,
    parameter  int unsigned TRK_MAX    = 63,
    localparam int unsigned CH_W       = width_of(N_CH),
    localparam int unsigned TRK_W      = width_of(TRK_MAX + 1),
    localparam int unsigned ACC_W      = TRK_W + width_of(2 * N_AVG)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmp,
    input  logic             start,
    input  logic             scan,
    input  logic [CH_W-1:0]  ch_in,
    input  logic             res_ready,
    output logic             PI1,
    output logic             PI2,
    output logic             PII1,
    output logic             PII2,
    output logic             PA,
    output logic             PB,
    output logic             PC,
    output logic             PD,
    output logic             s_BG2CMP,
    output logic             preChrg,
    output logic             setupBias,
    output logic             src_n,
    output logic             snk,
    output logic             cmp_p1,
    output logic             cmp_p2,
    output logic [CH_W-1:0]  ch_sel,
    output logic             busy,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_data,
    output logic [CH_W-1:0]  res_ch,
    output logic             res_err
);

    localparam int unsigned CYC_MAX =
        (PRECHG_CYC > DIODE_CYC) ? ((PRECHG_CYC > CHARGE_CYC) ? PRECHG_CYC : CHARGE_CYC)
                                 : ((DIODE_CYC  > CHARGE_CYC) ? DIODE_CYC  : CHARGE_CYC);
    localparam int unsigned CNT_W  = width_of(CYC_MAX);
    localparam int unsigned ITER_W = width_of(N_AVG + 1);

    logic scmp;

    state_e             state_q, state_d, tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TRK_W-1:0]   trk_q, trk_d, trk_inc;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               err_q, err_d, hchg_q, hchg_d, lchg_q, lchg_d;
    logic               ref_q, ref_d, p1_q, p1_d, p2_q, p2_d, arm_q, arm_d;
    logic               pi_q, pi_d, pii_q, pii_d, pa_q, pa_d, pb_q, pb_d;
    logic               pc_q, pc_d, pd_q, pd_d, bg_q, bg_d, pre_q, pre_d;
    logic               src_q, src_d, snk_q, snk_d, busy_q, busy_d, valid_q, valid_d;

    tsense_cmp_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .cmp     (cmp),
        .scmp    (scmp)
    );

    // Tracking count including the current cycle, saturating at the timeout
    assign trk_inc = (trk_q == TRK_W'(TRK_MAX)) ? trk_q : trk_q + TRK_W'(1);

    // Next-state and datapath update; nothing moves until one cycle after reset release
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        trk_d   = trk_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        ch_d    = ch_q;
        err_d   = err_q;
        hchg_d  = hchg_q;
        lchg_d  = lchg_q;
        ref_d   = ref_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        arm_d   = 1'b1;
        if (arm_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ch_d    = ch_in;
                        acc_d   = '0;
                        iter_d  = '0;
                        err_d   = 1'b0;
                        hchg_d  = 1'b0;
                        lchg_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_PRECHARGE;
                    end
                end
                ST_PRECHARGE: begin
                    if (cnt_q == CNT_W'(PRECHG_CYC - 1)) begin
                        cnt_d   = '0;
                        p1_d    = ~p1_q;
                        p2_d    = ~p2_q;
                        tgt_d   = ST_BIGDIODE;
                        state_d = ST_BLANK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_BLANK: begin
                    ref_d   = scmp;
                    cnt_d   = '0;
                    trk_d   = '0;
                    state_d = tgt_q;
                end
                ST_BIGDIODE: begin
                    trk_d = trk_inc;
                    if ((scmp != ref_q) || (trk_inc == TRK_W'(TRK_MAX))) begin
                        if (scmp == ref_q) begin
                            err_d = 1'b1;
                        end
                        acc_d   = acc_q + ACC_W'(trk_inc);
                        trk_d   = '0;
                        tgt_d   = ST_DIODE;
                        state_d = ST_BLANK;
                    end
                end
                ST_DIODE: begin
                    if (cnt_q == CNT_W'(DIODE_CYC - 1)) begin
                        cnt_d   = '0;
                        p1_d    = ~p1_q;
                        p2_d    = ~p2_q;
                        tgt_d   = hchg_q ? ST_LCHARGE : ST_HCHARGE;
                        state_d = ST_BLANK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HCHARGE: begin
                    if (cnt_q == CNT_W'(CHARGE_CYC - 1)) begin
                        cnt_d   = '0;
                        hchg_d  = 1'b1;
                        tgt_d   = ST_BIGDIODE;
                        state_d = ST_BLANK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LCHARGE: begin
                    if (cnt_q == CNT_W'(CHARGE_CYC - 1)) begin
                        cnt_d   = '0;
                        lchg_d  = 1'b1;
                        state_d = ST_OUTPUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    hchg_d = 1'b0;
                    lchg_d = 1'b0;
                    iter_d = iter_q + ITER_W'(1);
                    if (iter_d < ITER_W'(N_AVG)) begin
                        tgt_d   = ST_BIGDIODE;
                        state_d = ST_BLANK;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        if (scan) begin
                            ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
                            acc_d   = '0;
                            iter_d  = '0;
                            err_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_PRECHARGE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Phase decode of the upcoming state so switch controls leave a flop
    always_comb begin
        pi_d    = 1'b0;
        pii_d   = 1'b0;
        pa_d    = 1'b0;
        pb_d    = 1'b0;
        pc_d    = 1'b0;
        pd_d    = 1'b0;
        bg_d    = 1'b0;
        pre_d   = 1'b0;
        src_d   = 1'b0;
        snk_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        case (state_d)
            ST_PRECHARGE: begin
                pre_d = 1'b1;
                bg_d  = 1'b1;
                pb_d  = 1'b1;
                pc_d  = 1'b1;
                pd_d  = 1'b1;
            end
            ST_BIGDIODE: begin
                pi_d  = 1'b1;
                src_d = ~scmp;
                snk_d = scmp;
            end
            ST_DIODE: pii_d = 1'b1;
            ST_HCHARGE: begin
                pa_d = 1'b1;
                pb_d = 1'b1;
                bg_d = 1'b1;
            end
            ST_LCHARGE: begin
                pa_d = 1'b1;
                pc_d = 1'b1;
                bg_d = 1'b1;
            end
            ST_OUTPUT: begin
                pb_d = 1'b1;
                pc_d = 1'b1;
                pd_d = 1'b1;
            end
            ST_HOLD: begin
                pb_d    = 1'b1;
                pc_d    = 1'b1;
                pd_d    = 1'b1;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tgt_q   <= ST_IDLE;
            cnt_q   <= '0;
            trk_q   <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
            hchg_q  <= 1'b0;
            lchg_q  <= 1'b0;
            ref_q   <= 1'b0;
            p1_q    <= 1'b1;
            p2_q    <= 1'b0;
            arm_q   <= 1'b0;
            pi_q    <= 1'b0;
            pii_q   <= 1'b0;
            pa_q    <= 1'b0;
            pb_q    <= 1'b0;
            pc_q    <= 1'b0;
            pd_q    <= 1'b0;
            bg_q    <= 1'b0;
            pre_q   <= 1'b0;
            src_q   <= 1'b0;
            snk_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            trk_q   <= trk_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
            hchg_q  <= hchg_d;
            lchg_q  <= lchg_d;
            ref_q   <= ref_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            arm_q   <= arm_d;
            pi_q    <= pi_d;
            pii_q   <= pii_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            pc_q    <= pc_d;
            pd_q    <= pd_d;
            bg_q    <= bg_d;
            pre_q   <= pre_d;
            src_q   <= src_d;
            snk_q   <= snk_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign PI1       = pi_q;
    assign PI2       = pi_q;
    assign PII1      = pii_q;
    assign PII2      = pii_q;
    assign PA        = pa_q;
    assign PB        = pb_q;
    assign PC        = pc_q;
    assign PD        = pd_q;
    assign s_BG2CMP  = bg_q;
    assign preChrg   = pre_q;
    assign setupBias = pre_q;
    assign src_n     = src_q;
    assign snk       = snk_q;
    assign cmp_p1    = p1_q;
    assign cmp_p2    = p2_q;
    assign ch_sel    = ch_q;
    assign busy      = busy_q;
    assign res_valid = valid_q;
    assign res_data  = acc_q;
    assign res_ch    = ch_q;
    assign res_err   = err_q;

endmodule

// File: doc/tsense_seq.md
TSENSE_SEQ -- requirements
Module: tsense_seq

Interface
REQ-001 Parameter N_CH, default 4: number of diode channels selectable through ch_sel.
REQ-002 Parameter PRECHG_CYC, default 26: number of PRECHARGE cycles.
REQ-003 Parameter DIODE_CYC, default 9: number of DIODE cycles.
REQ-004 Parameter CHARGE_CYC, default 6: number of HCHARGE and LCHARGE cycles.
REQ-005 Parameter N_AVG, default 4: H/L iterations accumulated per result.
REQ-006 Parameter TRK_MAX, default 63: BIGDIODE timeout in cycles; TRK_W = clog2(TRK_MAX+1).
REQ-007 clk  in  1  sole clock; all logic on posedge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 cmp  in  1  asynchronous analog comparator output.
REQ-010 start  in  1  single-cycle conversion request, honoured only in IDLE.
REQ-011 scan  in  1  1 = auto-advance channel after each result; 0 = single shot.
REQ-012 ch_in  in  CH_W  starting channel, latched on an accepted start.
REQ-013 res_ready  in  1  result consumer ready.
REQ-014 PI1, PI2, PII1, PII2, PA, PB, PC, PD, s_BG2CMP, preChrg, setupBias  out  1 each  switch phase controls.
REQ-015 src_n, snk  out  1 each  tracking current source and sink controls.
REQ-016 cmp_p1, cmp_p2  out  1 each  complementary comparator chop phases.
REQ-017 ch_sel  out  CH_W  active channel.
REQ-018 busy  out  1  high whenever not IDLE.
REQ-019 res_valid, res_data [TRK_W+clog2(2*N_AVG)], res_ch [CH_W], res_err  out  result handshake and payload.

Function
REQ-020 States SHALL be IDLE, PRECHARGE, BLANK, BIGDIODE, DIODE, HCHARGE, LCHARGE, OUTPUT, HOLD.
REQ-021 IDLE + start SHALL latch ch_in into ch_sel and clear acc, iter, err and the H/L flags; next state PRECHARGE.
REQ-022 PRECHARGE SHALL hold preChrg=setupBias=s_BG2CMP=PB=PC=PD=1 for exactly PRECHG_CYC cycles, then toggle cmp_p1/cmp_p2 and enter BLANK with target BIGDIODE.
REQ-023 BLANK SHALL last one cycle with every phase output 0 (non-overlap), capture synchronised cmp into ref, then enter target.
REQ-024 BIGDIODE SHALL assert PI1=PI2=1 and increment trk, saturating at TRK_MAX.
REQ-025 In BIGDIODE, scmp=0 SHALL drive src_n=1 and snk=0; scmp=1 SHALL drive src_n=0 and snk=1; both are 0 in every other state.
REQ-026 BIGDIODE SHALL exit to BLANK with target DIODE when scmp!=ref, or when trk==TRK_MAX; the timeout exit also sets err.
REQ-027 On BIGDIODE exit, acc SHALL add trk (unsigned, no overflow by width rule) and trk SHALL clear.
REQ-028 DIODE SHALL assert PII1=PII2=1 for DIODE_CYC cycles, then toggle the chop phases and enter BLANK.
REQ-029 The DIODE exit target SHALL be HCHARGE if Hcharged=0, else LCHARGE.
REQ-030 HCHARGE SHALL drive PA=PB=s_BG2CMP=1 for CHARGE_CYC cycles, set Hcharged, then enter BLANK with target BIGDIODE.
REQ-031 LCHARGE SHALL drive PA=PC=s_BG2CMP=1 for CHARGE_CYC cycles, set Lcharged, then enter OUTPUT.
REQ-032 OUTPUT SHALL last one cycle with PB=PC=PD=1, clear both flags and increment iter.
REQ-033 From OUTPUT: if iter<N_AVG, next state SHALL be BLANK with target BIGDIODE; otherwise HOLD.
REQ-034 HOLD SHALL assert res_valid with res_data=acc, res_ch=ch_sel, res_err=err, and drive PB=PC=PD=1.
REQ-035 Payload SHALL stay stable until the cycle res_valid and res_ready are both high.
REQ-036 Handshake completion with scan=1 SHALL advance ch_sel (wrap N_CH-1→0), clear acc, iter and err, and enter PRECHARGE; with scan=0 it SHALL enter IDLE.
REQ-037 start outside IDLE SHALL be ignored; scan SHALL be sampled only at handshake completion.

Reset
REQ-038 Asserting reset_n=0 SHALL asynchronously, at any state, force IDLE and set cmp_p1=1, with every other output 0 (ch_sel, counters, acc and flags 0).
REQ-039 The first state transition after deassertion SHALL occur no earlier than the second posedge.

Structure
REQ-040 Package tsense_pkg SHALL hold the state enum and a clog2-based width helper.
REQ-041 Sub-module tsense_cmp_sync SHALL be a 2-flop synchroniser (cmp→scmp, reset to 0); all cmp uses SHALL take scmp.

Verification
REQ-042 Defaults, start, ch_in=2, cmp flips 10 cycles into each BIGDIODE -> preChrg high exactly 26 cycles, res_valid with res_ch=2, res_err=0, res_data equal to the summed trk counts.
REQ-043 cmp held constant -> every BIGDIODE ends at 63 cycles, res_err=1.
REQ-044 scan=1, ch_in=3, N_CH=4 -> second result res_ch=0.
REQ-045 res_ready held low 20 cycles in HOLD -> res_valid and payload stable, no phase change.
REQ-046 reset_n pulsed low mid-HCHARGE -> all outputs 0 immediately, cmp_p1=1, busy=0.
REQ-047 Phase-overlap checker over a full conversion -> no cycle with PI*/PII* together, or with PI*/PII* and PA..PD together.
